// File: rtl/mem_xlate_ctrl_if.sv
// +----------------------------------------------------------------------+
// | mem_xlate_ctrl_if : external SRAM/peripheral bus bundle               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_xlate_ctrl_if;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    modport master (
        output bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        input  bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i
    );
endinterface

`default_nettype wire

// File: rtl/mem_xlate_ctrl.sv
// +----------------------------------------------------------------------+
// | mem_xlate_ctrl : MEM-stage TLB translation and bus transaction ctrl   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_xlate_ctrl #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [4:0]  EXC_TLBL       = 5'd2,
    parameter logic [4:0]  EXC_TLBS       = 5'd3,
    parameter logic [4:0]  EXC_DBE        = 5'd7
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        req_i,
    input  wire logic        we_i,
    input  wire logic [3:0]  sel_i,
    input  wire logic [31:0] vaddr_i,
    input  wire logic [31:0] wdata_i,
    input  wire logic        flush_i,
    output logic [31:0]      tlb_vaddr_o,
    input  wire logic        tlb_hit_i,
    input  wire logic [31:0] tlb_paddr_i,
    mem_xlate_ctrl_if.master bus,
    output logic             stall_o,
    output logic [31:0]      rdata_o,
    output logic             rdata_valid_o,
    output logic             exc_valid_o,
    output logic [4:0]       exc_code_o,
    output logic [31:0]      badvaddr_o
);

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_vaddr;
    logic [7:0]  r_cnt;
    logic        r_discard;
    logic        w_req_go;
    logic        w_timeout;
    logic        w_discard;

    assign w_req_go  = req_i & ~flush_i;
    assign w_timeout = (r_cnt == C_CNT_LAST);
    // A flush arriving on the completing cycle must suppress the result too.
    assign w_discard = r_discard | flush_i;

    assign tlb_vaddr_o = (r_state == S_IDLE) ? vaddr_i : r_vaddr;
    assign stall_o     = ((r_state == S_IDLE) & w_req_go) | (r_state == S_BUSY);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req_go) w_state_next = tlb_hit_i ? S_BUSY : S_DONE;
            S_BUSY:  if (bus.bus_ack_i || w_timeout) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_vaddr         <= '0;
            r_cnt           <= '0;
            r_discard       <= 1'b0;
            bus.bus_ce_o    <= 1'b0;
            bus.bus_we_o    <= 1'b0;
            bus.bus_sel_o   <= '0;
            bus.bus_addr_o  <= '0;
            bus.bus_wdata_o <= '0;
            rdata_o         <= '0;
            rdata_valid_o   <= 1'b0;
            exc_valid_o     <= 1'b0;
            exc_code_o      <= '0;
            badvaddr_o      <= '0;
        end else begin
            r_state       <= w_state_next;
            rdata_valid_o <= 1'b0;
            exc_valid_o   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_go) begin
                        r_vaddr <= vaddr_i;
                        if (tlb_hit_i) begin
                            bus.bus_ce_o    <= 1'b1;
                            bus.bus_we_o    <= we_i;
                            bus.bus_sel_o   <= sel_i;
                            bus.bus_addr_o  <= tlb_paddr_i;
                            bus.bus_wdata_o <= wdata_i;
                            r_cnt           <= '0;
                        end else begin
                            exc_valid_o <= 1'b1;
                            exc_code_o  <= we_i ? EXC_TLBS : EXC_TLBL;
                            badvaddr_o  <= vaddr_i;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush_i) r_discard <= 1'b1;
                    if (bus.bus_ack_i) begin
                        bus.bus_ce_o <= 1'b0;
                        if (!bus.bus_we_o && !w_discard) begin
                            rdata_o       <= bus.bus_rdata_i;
                            rdata_valid_o <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        bus.bus_ce_o <= 1'b0;
                        if (!w_discard) begin
                            exc_valid_o <= 1'b1;
                            exc_code_o  <= EXC_DBE;
                            badvaddr_o  <= r_vaddr;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_discard <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_xlate_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_mem_xlate_ctrl : directed self-checking bench for mem_xlate_ctrl   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_xlate_ctrl;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] vaddr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic [31:0] tlb_vaddr_o;
    logic        tlb_hit_i;
    logic [31:0] tlb_paddr_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        exc_valid_o;
    logic [4:0]  exc_code_o;
    logic [31:0] badvaddr_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_xlate_ctrl_if bus_if ();

    mem_xlate_ctrl #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .we_i          (we_i),
        .sel_i         (sel_i),
        .vaddr_i       (vaddr_i),
        .wdata_i       (wdata_i),
        .flush_i       (flush_i),
        .tlb_vaddr_o   (tlb_vaddr_o),
        .tlb_hit_i     (tlb_hit_i),
        .tlb_paddr_i   (tlb_paddr_i),
        .bus           (bus_if.master),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .exc_valid_o   (exc_valid_o),
        .exc_code_o    (exc_code_o),
        .badvaddr_o    (badvaddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] va, input logic hit,
                             input logic [31:0] pa);
        req_i       = 1'b1;
        we_i        = we;
        vaddr_i     = va;
        tlb_hit_i   = hit;
        tlb_paddr_i = pa;
        #1;
    endtask

    task automatic release_req();
        req_i            = 1'b0;
        bus_if.bus_ack_i = 1'b0;
        tlb_hit_i        = 1'b0;
    endtask

    int n_ce;

    initial begin
        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; sel_i = 4'hF; vaddr_i = 32'h0000_1234;
        wdata_i = 32'h0; flush_i = 1'b0; tlb_hit_i = 1'b0; tlb_paddr_i = 32'h0;
        bus_if.bus_rdata_i = 32'h0; bus_if.bus_ack_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_ce",       32'(bus_if.bus_ce_o), 32'd0);
        check("rst_rdata",    rdata_o, 32'h0);
        check("rst_exc",      32'(exc_valid_o), 32'd0);
        check("rst_stall",    32'(stall_o), 32'd0);
        check("rst_tlbva",    tlb_vaddr_o, 32'h0000_1234);

        // Load hit, ack on the second BUSY cycle
        tick();
        drive_req(1'b0, 32'h8000_1000, 1'b1, 32'h0000_1000);
        check("ld_stall_idle", 32'(stall_o), 32'd1);
        check("ld_tlbva_idle", tlb_vaddr_o, 32'h8000_1000);
        tick();
        check("ld_ce",     32'(bus_if.bus_ce_o), 32'd1);
        check("ld_addr",   bus_if.bus_addr_o, 32'h0000_1000);
        check("ld_we",     32'(bus_if.bus_we_o), 32'd0);
        vaddr_i = 32'h0; tlb_hit_i = 1'b0; #1;
        check("ld_tlbva_latched", tlb_vaddr_o, 32'h8000_1000);
        check("ld_stall_busy", 32'(stall_o), 32'd1);
        tick();
        check("ld_ce2",    32'(bus_if.bus_ce_o), 32'd1);
        bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = 32'hDEAD_BEEF;
        tick();
        check("ld_done_ce",    32'(bus_if.bus_ce_o), 32'd0);
        check("ld_rvalid",     32'(rdata_valid_o), 32'd1);
        check("ld_rdata",      rdata_o, 32'hDEAD_BEEF);
        check("ld_no_exc",     32'(exc_valid_o), 32'd0);
        check("ld_done_stall", 32'(stall_o), 32'd0);
        release_req();
        tick();
        check("ld_rvalid_pulse", 32'(rdata_valid_o), 32'd0);
        check("ld_idle_ce",      32'(bus_if.bus_ce_o), 32'd0);

        // Store miss
        drive_req(1'b1, 32'h0040_3000, 1'b0, 32'h0);
        check("sm_stall_idle", 32'(stall_o), 32'd1);
        tick();
        check("sm_ce",       32'(bus_if.bus_ce_o), 32'd0);
        check("sm_exc",      32'(exc_valid_o), 32'd1);
        check("sm_code",     32'(exc_code_o), 32'd3);
        check("sm_badva",    badvaddr_o, 32'h0040_3000);
        check("sm_done_stall", 32'(stall_o), 32'd0);
        release_req();
        tick();
        check("sm_exc_pulse", 32'(exc_valid_o), 32'd0);

        // Load miss
        drive_req(1'b0, 32'h1000_0004, 1'b0, 32'h0);
        tick();
        check("lm_code",  32'(exc_code_o), 32'd2);
        check("lm_badva", badvaddr_o, 32'h1000_0004);
        release_req();
        tick();

        // Timeout with TIMEOUT_CYCLES=4
        sel_i = 4'h3; wdata_i = 32'hCAFE_F00D;
        drive_req(1'b1, 32'h0000_2000, 1'b1, 32'h0001_2000);
        tick();
        check("to_we",    32'(bus_if.bus_we_o), 32'd1);
        check("to_sel",   32'(bus_if.bus_sel_o), 32'h3);
        check("to_wdata", bus_if.bus_wdata_o, 32'hCAFE_F00D);
        n_ce = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_if.bus_ce_o) n_ce++;
            else break;
        end
        check("to_ce_cycles", 32'(n_ce), 32'd4);
        check("to_exc",   32'(exc_valid_o), 32'd1);
        check("to_code",  32'(exc_code_o), 32'd7);
        check("to_badva", badvaddr_o, 32'h0000_2000);
        check("to_rvalid", 32'(rdata_valid_o), 32'd0);
        release_req();
        tick();
        check("to_exc_pulse", 32'(exc_valid_o), 32'd0);
        sel_i = 4'hF;

        // Flush mid-BUSY
        drive_req(1'b0, 32'h8000_2000, 1'b1, 32'h0000_2000);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = 32'h1111_1111;
        tick();
        check("fl_ce",     32'(bus_if.bus_ce_o), 32'd0);
        check("fl_rvalid", 32'(rdata_valid_o), 32'd0);
        check("fl_exc",    32'(exc_valid_o), 32'd0);
        check("fl_rdata",  rdata_o, 32'hDEAD_BEEF);
        release_req();
        tick();
        vaddr_i = 32'hABCD_0000; #1;
        check("fl_idle_tlbva", tlb_vaddr_o, 32'hABCD_0000);
        check("fl_idle_stall", 32'(stall_o), 32'd0);

        // Ack coincides with the final timeout count
        drive_req(1'b0, 32'h8000_3000, 1'b1, 32'h0000_3000);
        tick(); tick(); tick(); tick();
        bus_if.bus_ack_i = 1'b1; bus_if.bus_rdata_i = 32'h5A5A_A5A5;
        tick();
        check("at_rvalid", 32'(rdata_valid_o), 32'd1);
        check("at_rdata",  rdata_o, 32'h5A5A_A5A5);
        check("at_no_exc", 32'(exc_valid_o), 32'd0);
        release_req();
        tick();

        // Reset mid-BUSY
        drive_req(1'b0, 32'h8000_4000, 1'b1, 32'h0000_4000);
        tick();
        check("rb_ce_busy", 32'(bus_if.bus_ce_o), 32'd1);
        rst = 1'b1; req_i = 1'b0; tlb_hit_i = 1'b0;
        tick();
        check("rb_ce",    32'(bus_if.bus_ce_o), 32'd0);
        check("rb_addr",  bus_if.bus_addr_o, 32'h0);
        check("rb_rdata", rdata_o, 32'h0);
        check("rb_badva", badvaddr_o, 32'h0);
        check("rb_code",  32'(exc_code_o), 32'd0);
        check("rb_stall", 32'(stall_o), 32'd0);
        rst = 1'b0;
        vaddr_i = 32'h0000_5678; #1;
        check("rb_tlbva_idle", tlb_vaddr_o, 32'h0000_5678);
        tick();
        check("rb_ce_after", 32'(bus_if.bus_ce_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_xlate_ctrl.md
Name: mem_xlate_ctrl

Overview:
- Sits between the MEM pipeline stage and the external SRAM/peripheral bus, and consumes the combinational translation result of the TLB lookup block.
- Drives the virtual address into the TLB and accepts a load/store request from MEM. On a hit it runs a multi-cycle bus transaction, stalling the pipeline until ack.
- On a TLB miss it raises a TLBL/TLBS exception instead of touching the bus.
- A bus timeout raises a data-bus-error exception.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in BUSY without bus_ack_i before a bus error; legal range 2..255.
- EXC_TLBL, 5'd2: exception code for a load/fetch TLB miss.
- EXC_TLBS, 5'd3: exception code for a store TLB miss.
- EXC_DBE, 5'd7: exception code for a bus timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_i  in  1  MEM stage access request; held while stall_o=1
- we_i  in  1  1=store, 0=load
- sel_i  in  4  byte enables
- vaddr_i  in  32  virtual address
- wdata_i  in  32  store data
- flush_i  in  1  pipeline flush (exception/eret)
- tlb_vaddr_o  out  32  address presented to TLB lookup
- tlb_hit_i  in  1  TLB hit (combinational, same cycle)
- tlb_paddr_i  in  32  translated physical address
- bus_ce_o  out  1  bus cycle active
- bus_we_o  out  1  bus write
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  32  physical address
- bus_wdata_o  out  32  write data
- bus_rdata_i  in  32  read data
- bus_ack_i  in  1  transaction complete
- stall_o  out  1  stall request to pipeline control
- rdata_o  out  32  load result, valid in DONE
- rdata_valid_o  out  1  one-cycle load result strobe
- exc_valid_o  out  1  one-cycle exception strobe
- exc_code_o  out  5  exception code
- badvaddr_o  out  32  faulting virtual address

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - All registered outputs are 0: bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, rdata_o, rdata_valid_o, exc_valid_o, exc_code_o, badvaddr_o.
  - Timeout counter=0, discard flag=0.
  - Reset mid-BUSY abandons the transaction immediately; bus_ce_o drops on the next edge.
- tlb_vaddr_o:
  - IDLE: equals vaddr_i combinationally.
  - Other states: equals the latched vaddr.
- States: IDLE, BUSY, DONE.
- IDLE, on req_i=1 and flush_i=0:
  - Hit (tlb_hit_i=1): latch vaddr_i; drive bus_addr_o=tlb_paddr_i, bus_we_o=we_i, bus_sel_o=sel_i, bus_wdata_o=wdata_i, bus_ce_o=1. Clear the timeout counter and go to BUSY.
  - Miss (tlb_hit_i=0): next cycle exc_valid_o=1 for exactly one cycle, with exc_code_o=EXC_TLBS if we_i else EXC_TLBL and badvaddr_o=vaddr_i. Go to DONE. No bus cycle is issued.
  - req_i=0, or flush_i=1: remain in IDLE; strobes are 0.
- BUSY:
  - Bus outputs are held stable.
  - Counter increments each cycle without ack.
  - bus_ack_i=1 (takes priority over timeout in the same cycle): bus_ce_o<=0. For a load, rdata_o<=bus_rdata_i and rdata_valid_o<=1 for one cycle, unless discard is set. Go to DONE.
  - Counter==TIMEOUT_CYCLES-1 with no ack: bus_ce_o<=0; exc_valid_o<=1 with EXC_DBE and badvaddr_o=latched vaddr, unless discard is set. Go to DONE.
  - flush_i=1 in BUSY: set the discard flag. The bus cycle still completes (no abort). The result and exception strobes are suppressed.
- DONE:
  - Lasts exactly one cycle; stall_o=0.
  - req_i is ignored, so the held request is not reissued.
  - Clear discard; strobes return to 0; go to IDLE.
- stall_o (combinational):
  - 1 when in IDLE with req_i & tlb_hit_i & !flush_i.
  - 1 in BUSY.
  - 1 in IDLE on a miss request, until DONE.
  - 0 otherwise.
- Latency: hit with ack on the first BUSY cycle gives 3 cycles request-to-DONE. Miss gives 2 cycles.
- rdata_valid_o and exc_valid_o are never 1 together.

Test Plan:
- Load hit: req_i=1, we_i=0, vaddr=0x80001000, tlb_hit=1, paddr=0x00001000, ack after 2 cycles with rdata=0xDEADBEEF -> bus_addr_o=0x00001000; stall_o=1 until DONE; rdata_o=0xDEADBEEF with a single rdata_valid_o pulse.
- Store miss: we_i=1, vaddr=0x00403000, tlb_hit=0 -> bus_ce_o never asserts; exc_valid_o pulse with code 3 and badvaddr_o=0x00403000.
- Timeout: TIMEOUT_CYCLES=4, hit, no ack -> bus_ce_o high for exactly 4 cycles, then exc code 7 with badvaddr=vaddr.
- Flush mid-BUSY: flush_i pulsed in BUSY, ack 2 cycles later -> no rdata_valid_o and no exc_valid_o; returns to IDLE after DONE.
- Ack and timeout in the same cycle: ack arrives at counter==TIMEOUT_CYCLES-1 -> load data delivered; no exception.
- Reset mid-BUSY: rst asserted -> bus_ce_o=0 and state IDLE next cycle; all outputs 0.
